fifo_expwidth: RTL and testbench
================================

FIFO_EXPWIDTH -- requirements
Module: fifo_expwidth

Interface
REQ-001 Parameter WIDTH, default 32, data word width; SHALL be even, split into two equal slices.
REQ-002 Parameter DEPTH_P, default 3, log2 of depth; depth = 2**DEPTH_P = 8 entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 data_in  input  WIDTH  write word.
REQ-006 put  input  1  write request.
REQ-007 get  input  1  read request.
REQ-008 data_out  output  WIDTH  registered read word.
REQ-009 fillcount  output  DEPTH_P+1  number of stored entries, 0..8.
REQ-010 empty  output  1  high when fillcount==0.
REQ-011 full  output  1  high when fillcount==2**DEPTH_P.

Function
REQ-012 Storage SHALL be built as two WIDTH/2-wide, 8-deep FIFO slices under one shared control: low slice holds data_in[WIDTH/2-1:0], high slice holds data_in[WIDTH-1:WIDTH/2].
REQ-013 Both slices SHALL always hold identical occupancy; flags and fillcount come from the shared control.
REQ-014 Write: put=1 and not full at a rising edge SHALL store data_in at the write pointer and advance the pointer.
REQ-015 Read: get=1 and not empty at a rising edge SHALL load the oldest entry into data_out and advance the read pointer; latency 1 cycle, so the word is visible after that edge.
REQ-016 data_out SHALL hold its value on cycles without an accepted read.
REQ-017 Pointers SHALL be DEPTH_P bits and wrap from 7 to 0.
REQ-018 put while full, without get, SHALL be ignored: no store, no count change, no error.
REQ-019 get while empty SHALL be ignored: data_out and count unchanged.
REQ-020 put and get together with 0<fillcount<8 SHALL both execute; fillcount unchanged.
REQ-021 put and get together when full SHALL both execute: the oldest word is read, data_in is written, and fillcount stays 8.
REQ-022 put and get together when empty SHALL execute only the write: fillcount becomes 1, data_out unchanged, no bypass.
REQ-023 fillcount SHALL update by +1 on write only, -1 on read only, and 0 otherwise.
REQ-024 empty and full SHALL be combinational decodes of fillcount, valid in the same cycle as the count.

Reset
REQ-025 While reset=0, the block SHALL set fillcount=0, empty=1, full=0, data_out=0, and both pointers to 0, independent of clk.
REQ-026 Memory contents need not be cleared; entries left from before reset SHALL never be readable after reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored data; the first get after release with no put SHALL return nothing.

Verification
REQ-028 Reset, then 7 puts of 0x00,0x11,..,0x66 -> fillcount 1..7, empty=0 after the first put, full=0.
REQ-029 Next cycle put 0x77 with get -> data_out=0x00 and fillcount stays 7; then put 0x88 -> fillcount=8, full=1.
REQ-030 Put 0x99 while full, no get -> ignored; fillcount=8, full=1.
REQ-031 8 consecutive gets -> data_out 0x11,0x22,..,0x88 in order, fillcount 7..0, empty=1 at the end; further get leaves data_out=0x88.
REQ-032 On empty, put+get with 0x17 -> fillcount=1, data_out unchanged; put+get with 0x18 -> data_out=0x17, count 1; put 0x19 -> count 2; two gets -> data_out 0x18 then 0x19, empty=1.
REQ-033 Full FIFO with reset pulled low between clock edges -> outputs cleared immediately; after release, a get returns nothing and empty stays 1.

Source files
------------

// File: rtl/fifo_expwidth.sv
// 2**DEPTH_P-deep FIFO built from two half-width storage slices driven by one
// shared pointer/count controller; the read word is registered (1-cycle latency).

module fifo_expwidth_slice #(
    parameter int W       = 16,
    parameter int DEPTH_P = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [DEPTH_P-1:0] wr_ptr,
    input  logic [DEPTH_P-1:0] rd_ptr,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       dout
);
    localparam int DEPTH = 2 ** DEPTH_P;

    // Storage is never cleared; the shared count keeps stale entries unreachable.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= mem[rd_ptr];
        end
    end
endmodule

module fifo_expwidth #(
    parameter int WIDTH   = 32,
    parameter int DEPTH_P = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               put,
    input  logic               get,
    output logic [WIDTH-1:0]   data_out,
    output logic [DEPTH_P:0]   fillcount,
    output logic               empty,
    output logic               full
);
    localparam int HALF = WIDTH / 2;
    localparam logic [DEPTH_P:0]   FULL_CNT = {1'b1, {DEPTH_P{1'b0}}};
    localparam logic [DEPTH_P-1:0] PTR_ONE  = DEPTH_P'(1);
    localparam logic [DEPTH_P:0]   CNT_ONE  = (DEPTH_P + 1)'(1);

    logic [DEPTH_P-1:0] wr_ptr;
    logic [DEPTH_P-1:0] rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign empty = (fillcount == '0);
    assign full  = (fillcount == FULL_CNT);

    // When full, a simultaneous read frees the slot being written (wr_ptr == rd_ptr);
    // the slice reads the old word before the write lands. No bypass when empty.
    assign rd_en = get && !empty;
    assign wr_en = put && (!full || rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fillcount <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   fillcount <= fillcount + CNT_ONE;
                2'b01:   fillcount <= fillcount - CNT_ONE;
                default: fillcount <= fillcount;
            endcase
        end
    end

    fifo_expwidth_slice #(.W(HALF), .DEPTH_P(DEPTH_P)) u_slice_lo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .din    (data_in[HALF-1:0]),
        .dout   (data_out[HALF-1:0])
    );

    fifo_expwidth_slice #(.W(WIDTH - HALF), .DEPTH_P(DEPTH_P)) u_slice_hi (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .din    (data_in[WIDTH-1:HALF]),
        .dout   (data_out[WIDTH-1:HALF])
    );
endmodule

// File: tb/tb_fifo_expwidth.sv
// Scoreboard bench for fifo_expwidth: a queue-based reference model predicts each
// cycle's data_out/fillcount; a monitor pops and compares one cycle after each edge.

module tb_fifo_expwidth;
    localparam int WIDTH   = 32;
    localparam int DEPTH_P = 3;
    localparam int DEPTH   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             put = 1'b0;
    logic             get = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic [DEPTH_P:0] fillcount;
    logic             empty;
    logic             full;

    fifo_expwidth #(.WIDTH(WIDTH), .DEPTH_P(DEPTH_P)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .put       (put),
        .get       (get),
        .data_out  (data_out),
        .fillcount (fillcount),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout = '0;
    exp_t             mon_e;
    int               checks = 0;
    int               failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("data_out",  64'(data_out),  64'(mon_e.dout));
            check("fillcount", 64'(fillcount), 64'(mon_e.cnt));
            check("empty",     64'(empty),     64'(mon_e.cnt == 0));
            check("full",      64'(full),      64'(mon_e.cnt == DEPTH));
        end
    end

    // One clock cycle of stimulus; called at a falling edge, returns at the next one.
    task automatic cyc(input logic p, input logic g, input logic [WIDTH-1:0] d);
        bit   do_rd;
        bit   do_wr;
        exp_t e;
        put     = p;
        get     = g;
        data_in = d;
        @(posedge clk);
        do_rd = g && (model_q.size() > 0);
        do_wr = p && ((model_q.size() < DEPTH) || do_rd);
        if (do_rd) model_dout = model_q.pop_front();
        if (do_wr) model_q.push_back(d);
        e.dout = model_dout;
        e.cnt  = model_q.size();
        exp_q.push_back(e);
        @(negedge clk);
        put = 1'b0;
        get = 1'b0;
    endtask

    // Reset pulled low between edges, held across an edge with a put pending.
    task automatic mid_reset();
        #3;
        reset = 1'b0;
        #1;
        check("rst_fillcount", 64'(fillcount), 64'(0));
        check("rst_empty",     64'(empty),     64'(1));
        check("rst_full",      64'(full),      64'(0));
        check("rst_data_out",  64'(data_out),  64'(0));
        model_q.delete();
        model_dout = '0;
        put     = 1'b1;
        data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_hold_fillcount", 64'(fillcount), 64'(0));
        check("rst_hold_data_out",  64'(data_out),  64'(0));
        put   = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        int thr_p;
        int thr_g;
        #1;
        check("init_fillcount", 64'(fillcount), 64'(0));
        check("init_empty",     64'(empty),     64'(1));
        check("init_full",      64'(full),      64'(0));
        check("init_data_out",  64'(data_out),  64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, WIDTH'(i * 32'h11));
        cyc(1'b1, 1'b1, 32'h77);
        cyc(1'b1, 1'b0, 32'h88);
        cyc(1'b1, 1'b0, 32'h99);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, '0);

        cyc(1'b1, 1'b1, 32'h17);
        cyc(1'b1, 1'b1, 32'h18);
        cyc(1'b1, 1'b0, 32'h19);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);

        // Full plus simultaneous put/get, with wide words exercising both slices.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, $urandom());
        cyc(1'b1, 1'b1, 32'hCAFE_F00D);
        cyc(1'b1, 1'b0, 32'h1234_5678);

        mid_reset();
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                thr_p = $urandom_range(10, 90);
                thr_g = $urandom_range(10, 90);
            end
            if (i % 700 == 699) begin
                mid_reset();
            end else begin
                cyc($urandom_range(0, 99) < thr_p, $urandom_range(0, 99) < thr_g, $urandom());
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
